karatsuba_mul_8_seq: RTL and testbench

KARATSUBA_MUL_8_SEQ -- requirements
Module: karatsuba_mul_8_seq

---
 rtl/karatsuba_mul_8_seq.sv | 191 +++++++++++++++++++
 tb/tb_karatsuba_mul_8_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mul_8_seq.sv
`default_nettype none
// ============================================================================
//  Module   : karatsuba_mul_8_seq
//  Purpose  : 8x8 carry-less (GF(2)) multiplier that time-multiplexes one
//             4x4 Karatsuba core over three cycles.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  karatsuba_mul_4 : combinational 4x4 -> 7-bit carry-less product,
//  itself built as one Karatsuba level over 2-bit halves.
// ----------------------------------------------------------------------------
module karatsuba_mul_4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [6:0] o_p
);

   logic [1:0] w_a_mid;
   logic [1:0] w_b_mid;
   logic [2:0] w_ph;
   logic [2:0] w_pl;
   logic [2:0] w_pm;
   logic [2:0] w_cross;

   function automatic logic [2:0] clmul2(input logic [1:0] a, input logic [1:0] b);
      clmul2 = {a[1] & b[1], (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
   endfunction

   assign w_a_mid = i_a[3:2] ^ i_a[1:0];
   assign w_b_mid = i_b[3:2] ^ i_b[1:0];

   assign w_ph    = clmul2(i_a[3:2], i_b[3:2]);
   assign w_pl    = clmul2(i_a[1:0], i_b[1:0]);
   assign w_pm    = clmul2(w_a_mid, w_b_mid);

   // Middle term: (ah+al)(bh+bl) - ah*bh - al*bl, all sums are XOR.
   assign w_cross = w_ph ^ w_pl ^ w_pm;

   assign o_p = {w_ph, 4'b0000} ^ {2'b00, w_cross, 2'b00} ^ {4'b0000, w_pl};

endmodule

// ----------------------------------------------------------------------------
//  karatsuba_mul_8_seq : top level sequencer.
// ----------------------------------------------------------------------------
module karatsuba_mul_8_seq #(
   parameter int m = 8,
   parameter int n = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [m-1:0] A,
   input  logic [m-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] C,
   output logic         busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MUL_H = 3'd1,
      MUL_L = 3'd2,
      MUL_M = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [m-1:0] r_ar;
   logic [m-1:0] r_br;
   logic [6:0]   r_p1;
   logic [6:0]   r_p0;
   logic [6:0]   r_pm;
   logic [n-1:0] r_c;

   logic [3:0]   w_mul_a;
   logic [3:0]   w_mul_b;
   logic [6:0]   w_mul_p;
   logic [6:0]   w_cross;
   logic         w_accept;

   // ------------------------------------------------------------------
   //  State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   //  Next state and Moore outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = IDLE;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            w_accept = in_valid;
            w_state_nxt = in_valid ? MUL_H : IDLE;
         end
         MUL_H: w_state_nxt = MUL_L;
         MUL_L: w_state_nxt = MUL_M;
         MUL_M: w_state_nxt = DONE;
         DONE: begin
            out_valid   = 1'b1;
            w_state_nxt = out_ready ? IDLE : DONE;
         end
         // Unused encodings fall back to IDLE on the next edge.
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   //  Operand selection for the shared 4x4 core
   // ------------------------------------------------------------------
   always_comb begin
      w_mul_a = r_ar[3:0];
      w_mul_b = r_br[3:0];
      case (r_state)
         MUL_H: begin
            w_mul_a = r_ar[7:4];
            w_mul_b = r_br[7:4];
         end
         MUL_M: begin
            w_mul_a = r_ar[7:4] ^ r_ar[3:0];
            w_mul_b = r_br[7:4] ^ r_br[3:0];
         end
         default: begin
            w_mul_a = r_ar[3:0];
            w_mul_b = r_br[3:0];
         end
      endcase
   end

   karatsuba_mul_4 u_mul4 (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_mul_p)
   );

   // Pm is consumed in the same cycle it is produced, so the live core output is used.
   assign w_cross = r_p1 ^ r_p0 ^ w_mul_p;

   // ------------------------------------------------------------------
   //  Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ar <= '0;
         r_br <= '0;
         r_p1 <= '0;
         r_p0 <= '0;
         r_pm <= '0;
         r_c  <= '0;
      end else begin
         if (w_accept) begin
            r_ar <= A;
            r_br <= B;
         end
         if (r_state == MUL_H) begin
            r_p1 <= w_mul_p;
         end
         if (r_state == MUL_L) begin
            r_p0 <= w_mul_p;
         end
         if (r_state == MUL_M) begin
            r_pm <= w_mul_p;
            r_c  <= {r_p1, 8'h00} ^ {4'h0, w_cross, 4'h0} ^ {8'h00, r_p0};
         end
      end
   end

   assign C = r_c;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_mul_8_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_karatsuba_mul_8_seq
//  Purpose  : Self-checking bench for karatsuba_mul_8_seq against a
//             schoolbook carry-less reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_karatsuba_mul_8_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] C;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   karatsuba_mul_8_seq #(.m(8), .n(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .C         (C),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Schoolbook shift-and-XOR product.
   function automatic logic [14:0] clmul8(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ (15'(a) << i);
      end
      return acc;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One transaction with latency, hold and post-transfer checks.
   task automatic run_one(input logic [7:0] a, input logic [7:0] b,
                          input int hold, input bit keep_valid);
      logic [14:0] exp;
      int          k;
      exp = clmul8(a, b);
      @(negedge clk);
      A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
      #1 check_eq("in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      if (!keep_valid) in_valid = 1'b0;
      A = 8'($urandom); B = 8'($urandom);
      check_eq("busy_after_accept", 32'(busy), 32'd1);
      check_eq("in_ready_busy", 32'(in_ready), 32'd0);
      k = 0;
      while (k < 8) begin
         @(posedge clk);
         #1;
         k++;
         if (keep_valid) begin A = 8'($urandom); B = 8'($urandom); end
         if (out_valid) break;
         out_ready = 1'($urandom);
      end
      out_ready = 1'b0;
      check_eq("latency_edges", 32'(k), 32'd3);
      check_eq("product", 32'(C), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (keep_valid) begin A = 8'($urandom); B = 8'($urandom); end
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_in_ready", 32'(in_ready), 32'd0);
         check_eq("hold_C", 32'(C), 32'(exp));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_eq("valid_drop", 32'(out_valid), 32'd0);
      check_eq("idle_after_xfer", 32'(in_ready), 32'd1);
      check_eq("C_retained", 32'(C), 32'(exp));
      @(posedge clk);
      #1;
      check_eq("no_extra_op", 32'(busy), 32'd0);
      check_eq("no_extra_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [14:0] q[$];
      logic [14:0] c_now;
      bit          acc;
      bit          xfer;
      int          sent;
      int          rcvd;
      int          cyc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_C", 32'(C), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_one(8'hFF, 8'hFF, 0, 1'b0);
      run_one(8'h87, 8'h02, 0, 1'b0);
      run_one(8'h11, 8'h11, 1, 1'b0);
      run_one(8'h80, 8'h80, 0, 1'b0);
      run_one(8'h00, 8'hAB, 0, 1'b0);
      run_one(8'h03, 8'h03, 6, 1'b0);
      run_one(8'hC5, 8'h3A, 2, 1'b1);
      check_eq("const_FFxFF", 32'(clmul8(8'hFF, 8'hFF)), 32'h5555);

      // Reset pulse while the core is in MUL_L.
      @(negedge clk);
      A = 8'h9D; B = 8'hE7; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("abort_valid", 32'(out_valid), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_C", 32'(C), 32'd0);
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_one(8'h5B, 8'hD2, 0, 1'b0);

      // Random stream with random in_valid and out_ready, in-order scoreboard.
      sent = 0; rcvd = 0; cyc = 0;
      while ((sent < 1000 || rcvd < 1000) && cyc < 40000) begin
         @(negedge clk);
         in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
         A         = 8'($urandom);
         B         = 8'($urandom);
         out_ready = 1'($urandom);
         #1;
         acc   = in_valid && in_ready;
         xfer  = out_valid && out_ready;
         c_now = C;
         @(posedge clk);
         cyc++;
         if (acc) begin
            q.push_back(clmul8(A, B));
            sent++;
         end
         if (xfer) begin
            if (q.size() == 0) begin
               check_eq("stream_spurious", 32'd1, 32'd0);
            end else begin
               check_eq("stream_C", 32'(c_now), 32'(q.pop_front()));
            end
            rcvd++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check_eq("stream_done", 32'(rcvd), 32'd1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
